// File: rtl/vga_dither_out.sv
// TinyVGA PMOD output stage: 4x4 Bayer dither of 8-bit RGB down to 2 bits per channel,
// blanking, pin packing with delay-matched syncs, plus the frame counter for pattern logic.
module vga_dither_out #(
    parameter int DITHER_EN = 1,
    parameter int TEMPORAL  = 1,
    parameter int FRAME_W   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               display_on,
    input  logic [9:0]         hpos,
    input  logic [9:0]         vpos,
    input  logic [7:0]         r_in,
    input  logic [7:0]         g_in,
    input  logic [7:0]         b_in,
    output logic [7:0]         uo_out,
    output logic [FRAME_W-1:0] frame_count,
    output logic               frame_start
);

    // Indexed by {y[1:0], x[1:0]}
    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    logic               vsync_prev_q;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               fstart_q, fstart_d;

    logic       hs1_q, vs1_q, de1_q;
    logic [7:0] r1_q, g1_q, b1_q;
    logic [3:0] t1_q, t_d, t_raw;

    logic [7:0] uo_q, uo_d;
    logic [1:0] qr, qg, qb;

    // Only the low two position bits select the matrix cell.
    logic unused_pos;
    assign unused_pos = ^{hpos[9:2], vpos[9:2]};

    function automatic logic [1:0] quant(input logic [7:0] v, input logic [3:0] t);
        logic [8:0] s;
        s = {1'b0, v} + {3'b000, t, 2'b00};
        return s[8] ? 2'b11 : s[7:6];
    endfunction

    always_comb begin
        fstart_d = vsync_in & ~vsync_prev_q;
        frame_d  = frame_q + FRAME_W'(fstart_d);
    end

    // Odd frames use the complemented threshold (15 - t) to average out the pattern.
    always_comb begin
        t_raw = BAYER[{vpos[1:0], hpos[1:0]}];
        t_d   = t_raw;
        if (TEMPORAL != 0 && frame_q[0]) t_d = ~t_raw;
        if (DITHER_EN == 0) t_d = 4'd0;
    end

    always_comb begin
        qr = quant(r1_q, t1_q);
        qg = quant(g1_q, t1_q);
        qb = quant(b1_q, t1_q);
        if (!de1_q) begin
            qr = 2'b00;
            qg = 2'b00;
            qb = 2'b00;
        end
        uo_d = {hs1_q, qb[0], qg[0], qr[0], vs1_q, qb[1], qg[1], qr[1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_prev_q <= 1'b0;
            frame_q      <= '0;
            fstart_q     <= 1'b0;
            hs1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            de1_q        <= 1'b0;
            r1_q         <= 8'd0;
            g1_q         <= 8'd0;
            b1_q         <= 8'd0;
            t1_q         <= 4'd0;
            uo_q         <= 8'd0;
        end else begin
            vsync_prev_q <= vsync_in;
            frame_q      <= frame_d;
            fstart_q     <= fstart_d;
            hs1_q        <= hsync_in;
            vs1_q        <= vsync_in;
            de1_q        <= display_on;
            r1_q         <= r_in;
            g1_q         <= g_in;
            b1_q         <= b_in;
            t1_q         <= t_d;
            uo_q         <= uo_d;
        end
    end

    assign uo_out      = uo_q;
    assign frame_count = frame_q;
    assign frame_start = fstart_q;

endmodule
